// File: rtl/gear_adder_ecu.sv
// GeAr approximate adder with a sequential error-correction loop: approximate results in one
// cycle, or exact results after injecting one missed sub-adder carry per cycle.
module gear_adder_ecu #(
    parameter int unsigned N = 16,
    parameter int unsigned R = 2,
    parameter int unsigned P = 4,
    localparam int unsigned K = (N - P) / R,
    localparam int unsigned CW = $clog2(K)
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          mode_i,
    input  logic [N-1:0]  in1_i,
    input  logic [N-1:0]  in2_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [N:0]    res_o,
    output logic          err_o,
    output logic [CW-1:0] corr_cycles_o
);

    localparam int unsigned W = R + P;

    if (R < 1 || P < 1 || N <= R + P || (N - P) % R != 0) begin : g_bad_params
        $error("gear_adder_ecu: illegal N/R/P combination");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  a_q, b_q;
    logic          mode_q;
    logic [K-1:1]  c_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    res_q;
    logic          err_q;
    logic [CW-1:0] corr_q;
    logic          valid_q;

    logic [K-1:0]  cin;
    logic [W:0]    sub_sum;
    logic [N:0]    gear_res;
    logic [K-1:1]  err_vec;
    logic [K-1:1]  fix_vec;
    logic          err_now;

    assign cin = {c_q, 1'b0};

    always_comb begin
        sub_sum  = '0;
        gear_res = '0;
        err_vec  = '0;
        for (int unsigned i = 0; i < K; i++) begin
            sub_sum = {1'b0, a_q[i*R +: W]} + {1'b0, b_q[i*R +: W]} + {{W{1'b0}}, cin[i]};
            if (i == 0) begin
                gear_res[W-1:0] = sub_sum[W-1:0];
            end else begin
                gear_res[i*R+P +: R] = sub_sum[W-1:P];
            end
            if (i == K - 1) begin
                gear_res[N] = sub_sum[W];
            end else begin
                // Carry into relative bit R recovered from the sum bit and both operand bits.
                err_vec[i+1] = (sub_sum[R] ^ a_q[i*R+R] ^ b_q[i*R+R]) & ~cin[i+1];
            end
        end
    end

    assign err_now = |err_vec;
    assign fix_vec = err_vec & (-err_vec);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            c_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            corr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_q     <= in1_i;
                        b_q     <= in2_i;
                        mode_q  <= mode_i;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (!mode_q || !err_now) begin
                        res_q   <= gear_res;
                        corr_q  <= cnt_q;
                        err_q   <= mode_q ? (cnt_q != '0) : err_now;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        c_q   <= c_q | fix_vec;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign out_valid_o   = valid_q;
    assign res_o         = res_q;
    assign err_o         = err_q;
    assign corr_cycles_o = corr_q;

endmodule

// File: tb/tb_gear_adder_ecu.sv
// Bench for gear_adder_ecu: directed and random operations checked against a window-arithmetic
// GeAr/correction model, with latency, stall, and mid-operation reset checks.
module tb_gear_adder_ecu;

    localparam int N  = 16;
    localparam int R  = 2;
    localparam int P  = 4;
    localparam int K  = (N - P) / R;
    localparam int W  = R + P;
    localparam int CW = 3;

    typedef struct {
        logic [N:0] res;
        logic       err;
        int         k;
        int         acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [N-1:0]  in1, in2;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N:0]    res;
    logic          err;
    logic [CW-1:0] corr;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;
    logic man_rdy  = 1'b0;
    bit   lat_seen = 1'b0;
    exp_t exp_q[$];

    gear_adder_ecu #(.N(N), .R(R), .P(P)) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .mode_i       (mode),
        .in1_i        (in1),
        .in2_i        (in2),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .res_o        (res),
        .err_o        (err),
        .corr_cycles_o(corr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic int blk(input int x, input int i, input int w);
        return (x >> (i * R)) & ((1 << w) - 1);
    endfunction

    // Exact mode: sum is plain a+b; k counts lowest-first carry injections.
    // Approximate mode: assemble the windowed GeAr sum with all carry-ins zero.
    // err: some R-bit block generates a carry on its own (carry-ins all zero).
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
        exp_t        e;
        int          c[K];
        int          ai, bi, s;
        bit          found;
        logic [31:0] r;
        ai = int'(a);
        bi = int'(b);
        for (int i = 0; i < K; i++) c[i] = 0;
        e.err = 1'b0;
        for (int i = 1; i < K; i++)
            if (blk(ai, i - 1, R) + blk(bi, i - 1, R) >= (1 << R)) e.err = 1'b1;
        e.k   = 0;
        e.acc = 0;
        if (m) begin
            found = 1'b1;
            while (found) begin
                found = 1'b0;
                for (int i = 1; i < K && !found; i++) begin
                    if (c[i] == 0 && blk(ai, i - 1, R) + blk(bi, i - 1, R) + c[i-1] >= (1 << R)) begin
                        c[i]  = 1;
                        e.k++;
                        found = 1'b1;
                    end
                end
            end
            r = 32'(ai + bi);
        end else begin
            r = '0;
            for (int i = 0; i < K; i++) begin
                s = blk(ai, i, W) + blk(bi, i, W);
                if (i == 0) r = r | 32'(s & ((1 << W) - 1));
                else        r = r | 32'(((s >> P) & ((1 << R) - 1)) << (i * R + P));
                if (i == K - 1) r = r | 32'(((s >> W) & 1) << N);
            end
        end
        e.res = r[N:0];
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = man_rdy;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'(0));
            end else begin
                if (!lat_seen) begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'(1 + exp_q[0].k));
                    lat_seen = 1'b1;
                end
                chk("res", 32'(res), 32'(exp_q[0].res));
                chk("err", 32'(err), 32'(exp_q[0].err));
                chk("corr_cycles", 32'(corr), 32'(exp_q[0].k));
                chk("in_ready_in_done", 32'(in_ready), 32'(0));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    lat_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                         input bit lit, input logic [N:0] lr, input logic le, input int lk);
        exp_t e;
        int   n;
        e = model(a, b, m);
        if (lit) begin
            chk("model_res", 32'(e.res), 32'(lr));
            chk("model_err", 32'(e.err), 32'(le));
            chk("model_k", 32'(e.k), 32'(lk));
            e.res = lr;
            e.err = le;
            e.k   = lk;
        end
        in1      = a;
        in2      = b;
        mode     = m;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'(1));
            in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1      = 16'($urandom);
        in2      = 16'($urandom);
        mode     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        int           n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        in1      = '0;
        in2      = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_res", 32'(res), 32'(0));
        chk("reset_err", 32'(err), 32'(0));
        chk("reset_corr", 32'(corr), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h000C0, 1'b1, 0);
        issue(16'h00FF, 16'h0001, 1'b1, 1'b1, 17'h00100, 1'b1, 4);
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b1, 17'h10000, 1'b1, 5);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h0FFC0, 1'b1, 0);
        wait_drain();

        // Stall DONE for three cycles while a second operation waits.
        man_rdy  = 1'b0;
        rdy_mode = 2;
        issue(16'h1234, 16'h0001, 1'b1, 1'b1, 17'h01235, 1'b0, 0);
        fork
            issue(16'h4321, 16'h1010, 1'b0, 1'b1, 17'h05331, 1'b0, 0);
            begin
                n = 0;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 3; i++) begin
                    chk("stall_valid", 32'(out_valid), 32'(1));
                    chk("stall_in_ready", 32'(in_ready), 32'(0));
                    if (i < 2) @(negedge clk);
                end
                man_rdy = 1'b1;
                @(negedge clk);
                chk("hs_cycle_in_ready", 32'(in_ready), 32'(0));
                @(negedge clk);
                chk("after_hs_in_ready", 32'(in_ready), 32'(1));
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Abort during the second correction cycle.
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b1, 17'h10000, 1'b1, 5);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_res", 32'(res), 32'(0));
        chk("abort_corr", 32'(corr), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_valid_after", 32'(out_valid), 32'(0));
        chk("abort_res_after", 32'(res), 32'(0));
        @(posedge clk);
        #1;
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b1, 17'h0FFFF, 1'b0, 0);
        wait_drain();

        rdy_mode = 1;
        for (int i = 0; i < 48; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? ~ra + 16'($urandom_range(0, 3)) : 16'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 0);
        end
        wait_drain();
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
